// File: rtl/uart_pkg.sv
// Shared UART constants: the selectable baud table and the NCO increment
// calculation used by the baud generator and future TX/RX engines.
package uart_pkg;

    localparam int BAUD_SEL_W = 3;
    localparam int NUM_BAUDS  = 8;

    localparam logic [31:0] BAUD_TABLE [NUM_BAUDS] = '{
        32'd1200, 32'd2400, 32'd4800, 32'd9600,
        32'd19200, 32'd38400, 32'd57600, 32'd115200
    };

    // round(baud * os * 2^acc_w / clk_hz); evaluated at elaboration only
    function automatic logic [63:0] baud_inc(
        input logic [63:0] clk_hz,
        input logic [63:0] baud,
        input logic [63:0] os,
        input int          acc_w
    );
        logic [63:0] num;
        num = (baud * os) << acc_w;
        return (num + (clk_hz >> 1)) / clk_hz;
    endfunction

endpackage

// File: rtl/uart_baud_gen_nco.sv
// Phase accumulator: adds inc every enabled cycle and registers the carry out
// as a one-cycle tick; the fractional remainder stays in the accumulator.
module uart_nco #(
    parameter int ACC_W = 24
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [ACC_W-1:0] inc,
    output logic             tick
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             tick_q, tick_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, inc};
        acc_d  = acc_q;
        tick_d = 1'b0;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d  = sum[ACC_W-1:0];
            tick_d = sum[ACC_W];
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_baud_gen.sv
// Baud-rate enable generator: NCO oversample tick plus bit/mid-bit ticks,
// run-time rate select (applied at bit boundaries) and start-bit resync.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int OVERSAMPLE  = 16,
    parameter int ACC_W       = 24,
    parameter int DEFAULT_SEL = 3
) (
    input  logic                          sysclk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          resync,
    input  logic [BAUD_SEL_W-1:0]         baud_sel,
    output logic                          os_tick,
    output logic                          bit_tick,
    output logic                          mid_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_cnt,
    output logic [BAUD_SEL_W-1:0]         sel_q
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BAUD_SEL_W-1:0] SEL_RST = BAUD_SEL_W'(DEFAULT_SEL);

    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4 || OVERSAMPLE > 64) begin : g_bad_os
        $error("uart_baud_gen: OVERSAMPLE must be even and within 4..64");
    end

    logic [ACC_W-1:0] inc_table [NUM_BAUDS];

    for (genvar gi = 0; gi < NUM_BAUDS; gi++) begin : g_inc
        localparam logic [63:0] INC64 =
            baud_inc(64'(CLK_HZ), 64'(BAUD_TABLE[gi]), 64'(OVERSAMPLE), ACC_W);
        // Keeps carries at least two cycles apart, so every tick is a clean pulse
        if ((64'(BAUD_TABLE[gi]) * 64'(OVERSAMPLE)) > (64'(CLK_HZ) / 64'd2)) begin : g_too_fast
            $error("uart_baud_gen: baud rate too high for CLK_HZ and OVERSAMPLE");
        end
        if (INC64 == 64'd0) begin : g_zero_inc
            $error("uart_baud_gen: baud increment rounds to zero, widen ACC_W");
        end
        assign inc_table[gi] = INC64[ACC_W-1:0];
    end

    logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [BAUD_SEL_W-1:0] sel_d;
    logic             rate_load;
    logic             nco_en;

    uart_nco #(
        .ACC_W (ACC_W)
    ) u_nco (
        .sysclk (sysclk),
        .rst    (rst),
        .clr    (resync),
        .en     (nco_en),
        .inc    (inc_q),
        .tick   (os_tick)
    );

    assign nco_en   = en & ~resync;
    assign bit_tick = os_tick & (os_cnt_q == CNT_LAST);
    assign mid_tick = os_tick & (os_cnt_q == CNT_MID);
    assign os_cnt   = os_cnt_q;

    always_comb begin
        os_cnt_d = os_cnt_q;
        if (resync) begin
            os_cnt_d = '0;
        end else if (en && os_tick) begin
            os_cnt_d = (os_cnt_q == CNT_LAST) ? '0 : os_cnt_q + 1'b1;
        end

        // A new rate only takes effect where no bit is in flight
        rate_load = ~en | resync | bit_tick;
        sel_d     = sel_q;
        inc_d     = inc_q;
        if (rate_load) begin
            sel_d = baud_sel;
            inc_d = inc_table[baud_sel];
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            os_cnt_q <= '0;
            sel_q    <= SEL_RST;
            inc_q    <= inc_table[SEL_RST];
        end else begin
            os_cnt_q <= os_cnt_d;
            sel_q    <= sel_d;
            inc_q    <= inc_d;
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: an arithmetic phase model predicts every
// os_tick; a monitor pops the predictions and compares them with the DUT outputs.
module tb_uart_baud_gen;

    localparam int OS  = 16;
    localparam int W   = 24;
    localparam int CLK = 50_000_000;
    localparam int DEF = 3;

    logic       sysclk = 1'b0;
    logic       rst;
    logic       en;
    logic       resync;
    logic [2:0] baud_sel;
    logic       os_tick;
    logic       bit_tick;
    logic       mid_tick;
    logic [3:0] os_cnt;
    logic [2:0] sel_q;

    uart_baud_gen #(
        .CLK_HZ      (CLK),
        .OVERSAMPLE  (OS),
        .ACC_W       (W),
        .DEFAULT_SEL (DEF)
    ) dut (
        .sysclk   (sysclk),
        .rst      (rst),
        .en       (en),
        .resync   (resync),
        .baud_sel (baud_sel),
        .os_tick  (os_tick),
        .bit_tick (bit_tick),
        .mid_tick (mid_tick),
        .os_cnt   (os_cnt),
        .sel_q    (sel_q)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        int cyc;
        int cnt;
        bit bt;
        bit mt;
        int sel;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_on   = 1'b0;

    int bauds [8] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};
    longint unsigned inc_tab [8];

    // Reference model: total phase since the last restart, ticks counted since restart
    longint unsigned m_phase;
    longint unsigned m_inc;
    int              m_sel;
    int              m_counted;
    bit              m_tick;

    function automatic longint unsigned tb_inc(int baud);
        longint unsigned scaled;
        scaled = longint'(baud) * OS * (64'd1 << W);
        return (2 * scaled + CLK) / (2 * CLK);
    endfunction

    task automatic check(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit carry_next();
        return ((m_phase + m_inc) >> W) != (m_phase >> W);
    endfunction

    // Edges still needed (with en=1) before the next tick appears
    function automatic int edges_to_tick();
        longint unsigned boundary;
        boundary = ((m_phase >> W) + 1) << W;
        return int'((boundary - m_phase + m_inc - 1) / m_inc);
    endfunction

    function automatic void model_edge();
        bit bt_now;
        bit load;
        longint unsigned nxt;
        bt_now = m_tick && ((m_counted % OS) == OS - 1);
        if (rst) begin
            m_phase   = 0;
            m_counted = 0;
            m_tick    = 1'b0;
            m_sel     = DEF;
            m_inc     = inc_tab[DEF];
        end else begin
            load = !en || resync || bt_now;
            if (resync) begin
                m_phase   = 0;
                m_counted = 0;
                m_tick    = 1'b0;
            end else if (en) begin
                if (m_tick) m_counted++;
                nxt     = m_phase + m_inc;
                m_tick  = (nxt >> W) != (m_phase >> W);
                m_phase = nxt;
            end else begin
                m_tick = 1'b0;
            end
            if (load) begin
                m_sel = int'(baud_sel);
                m_inc = inc_tab[baud_sel];
            end
        end
    endfunction

    task automatic step();
        exp_t e;
        model_edge();
        @(posedge sysclk);
        cyc++;
        if (m_tick) begin
            e.cyc = cyc;
            e.cnt = m_counted % OS;
            e.bt  = (e.cnt == OS - 1);
            e.mt  = (e.cnt == OS / 2 - 1);
            e.sel = m_sel;
            q.push_back(e);
        end
        #1;
    endtask

    always @(negedge sysclk) begin
        if (mon_on) begin
            exp_t e;
            bit   exp_here;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                check("missed_tick_cycle", cyc, e.cyc);
            end
            exp_here = (q.size() > 0) && (q[0].cyc == cyc);
            if (os_tick || exp_here) begin
                check("os_tick", os_tick, exp_here);
                if (os_tick && exp_here) begin
                    e = q.pop_front();
                    check("tick_os_cnt", os_cnt, e.cnt);
                    check("tick_bit_tick", bit_tick, e.bt);
                    check("tick_mid_tick", mid_tick, e.mt);
                    check("tick_sel_q", sel_q, e.sel);
                end
            end else if (bit_tick || mid_tick) begin
                check("derived_tick_without_os_tick", {bit_tick, mid_tick}, 0);
            end
        end
    end

    initial begin
        int n;
        int cnt_ticks;
        int first_tick;
        int last_tick;
        int bad_spacing;
        int frozen_ticks;
        int cnt_before;
        int rem;
        int en_hold;
        bit sel_held;

        foreach (inc_tab[i]) inc_tab[i] = tb_inc(bauds[i]);
        m_phase = 0; m_inc = inc_tab[DEF]; m_sel = DEF; m_counted = 0; m_tick = 1'b0;

        rst = 1'b1; en = 1'b1; resync = 1'b0; baud_sel = 3'd3;
        repeat (3) step();
        check("reset_os_tick", os_tick, 0);
        check("reset_bit_tick", bit_tick, 0);
        check("reset_mid_tick", mid_tick, 0);
        check("reset_os_cnt", os_cnt, 0);
        check("reset_sel_q", sel_q, DEF);
        mon_on = 1'b1;

        // 9600 from reset: first tick edge, spacing and long-run count
        rst = 1'b0;
        cnt_ticks = 0; first_tick = 0; last_tick = 0; bad_spacing = 0;
        for (int k = 1; k <= 12000; k++) begin
            step();
            if (os_tick) begin
                cnt_ticks++;
                if (first_tick == 0) first_tick = k;
                else if ((k - last_tick) != 325 && (k - last_tick) != 326) bad_spacing++;
                last_tick = k;
            end
        end
        check("first_tick_edge_9600", first_tick, 326);
        check("spacing_9600_outliers", bad_spacing, 0);
        check("tick_count_12000", cnt_ticks, int'((64'd12000 * inc_tab[3]) >> W));

        // Rate change mid-bit is deferred to the bit boundary
        n = 0;
        while ((m_counted % OS) != 5 && n < 20000) begin step(); n++; end
        check("reach_os_cnt5", os_cnt, 5);
        baud_sel = 3'd7;
        sel_held = 1'b1;
        n = 0;
        do begin
            step(); n++;
            if (sel_q != 3'd3) sel_held = 1'b0;
        end while (!bit_tick && n < 20000);
        check("bit_tick_reached", bit_tick, 1);
        check("sel_held_until_boundary", sel_held, 1);
        step();
        check("sel_after_boundary", sel_q, 7);

        cnt_ticks = 0; bad_spacing = 0; last_tick = 0; n = 0;
        while (cnt_ticks < 16 && n < 2000) begin
            n++;
            if (os_tick) begin
                cnt_ticks++;
                if (cnt_ticks >= 2 && (n - last_tick) != 27 && (n - last_tick) != 28) bad_spacing++;
                last_tick = n;
                if (cnt_ticks == 8) begin
                    check("sel7_mid_tick_on_8th", mid_tick, 1);
                    check("sel7_os_cnt_on_8th", os_cnt, 7);
                end
                if (cnt_ticks == 16) check("sel7_bit_tick_on_16th", bit_tick, 1);
                else check("sel7_no_early_bit_tick", bit_tick, 0);
            end
            step();
        end
        check("sel7_tick_budget", cnt_ticks, 16);
        check("spacing_115200_outliers", bad_spacing, 0);

        // Resync coincident with a carry: tick dropped, phase restarts at 9600
        n = 0;
        while (!carry_next() && n < 1000) begin step(); n++; end
        resync = 1'b1; baud_sel = 3'd3;
        step();
        resync = 1'b0;
        check("resync_drops_tick", os_tick, 0);
        check("resync_clears_os_cnt", os_cnt, 0);
        n = 0;
        do begin step(); n++; end while (!os_tick && n < 1000);
        check("resync_next_tick_edge", n, 326);

        // Freeze mid-bit for 1000 cycles, then resume on the same phase
        n = 0;
        while ((m_counted % OS) != 4 && n < 20000) begin step(); n++; end
        repeat (100) step();
        rem = edges_to_tick();
        cnt_before = int'(os_cnt);
        en = 1'b0;
        frozen_ticks = 0;
        repeat (1000) begin
            step();
            if (os_tick) frozen_ticks++;
        end
        check("freeze_no_ticks", frozen_ticks, 0);
        check("freeze_os_cnt_held", os_cnt, cnt_before);
        en = 1'b1;
        n = 0;
        do begin step(); n++; end while (!os_tick && n < 1000);
        check("resume_tick_offset", n, rem);

        // Reset mid-bit at sel 5, os_cnt 9
        baud_sel = 3'd5; resync = 1'b1;
        step();
        resync = 1'b0;
        n = 0;
        while ((m_counted % OS) != 9 && n < 20000) begin step(); n++; end
        check("pre_reset_os_cnt", os_cnt, 9);
        check("pre_reset_sel", sel_q, 5);
        rst = 1'b1;
        step();
        check("midbit_reset_os_tick", os_tick, 0);
        check("midbit_reset_os_cnt", os_cnt, 0);
        check("midbit_reset_sel_q", sel_q, DEF);
        rst = 1'b0; baud_sel = 3'd3;
        n = 0;
        do begin step(); n++; end while (!os_tick && n < 1000);
        check("post_reset_first_tick", n, 326);

        // Randomised traffic: rate changes, resyncs, enable gaps, rare resets
        en_hold = 0;
        for (int k = 0; k < 15000; k++) begin
            resync = ($urandom_range(0, 2999) == 0);
            rst    = ($urandom_range(0, 7999) == 0);
            if ($urandom_range(0, 799) == 0) baud_sel = 3'($urandom_range(4, 7));
            if (en_hold > 0) en_hold--;
            else if ($urandom_range(0, 1999) == 0) en_hold = $urandom_range(1, 300);
            en = (en_hold == 0);
            step();
        end
        rst = 1'b0; resync = 1'b0; en = 1'b1;
        repeat (50) step();
        @(negedge sysclk);
        #1;
        check("scoreboard_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
